// File: rtl/can_arb_field_ctrl_if.sv
// Bit-stream and identifier bus between bit-timing/destuff logic, the arbitration-field
// sequencer and the frame decoder. CAN_ACCEPT_FILTER_EN adds acceptance code/mask inputs.
interface can_arb_field_ctrl_if;
    logic        SP;
    logic        STUFF;
    logic        RX_BIT;
    logic        FRAME_END;
    logic [28:0] IDTFR;
    logic        IDE;
    logic        RTR;
    logic        ID_VALID;
    logic        BUSY;
    logic        FORM_ERR;
    logic        ACCEPT;
`ifdef CAN_ACCEPT_FILTER_EN
    logic [28:0] ACC_CODE;
    logic [28:0] ACC_MASK;

    modport master (
        output SP, STUFF, RX_BIT, FRAME_END, ACC_CODE, ACC_MASK,
        input  IDTFR, IDE, RTR, ID_VALID, BUSY, FORM_ERR, ACCEPT
    );
    modport slave (
        input  SP, STUFF, RX_BIT, FRAME_END, ACC_CODE, ACC_MASK,
        output IDTFR, IDE, RTR, ID_VALID, BUSY, FORM_ERR, ACCEPT
    );
`else
    modport master (
        output SP, STUFF, RX_BIT, FRAME_END,
        input  IDTFR, IDE, RTR, ID_VALID, BUSY, FORM_ERR, ACCEPT
    );
    modport slave (
        input  SP, STUFF, RX_BIT, FRAME_END,
        output IDTFR, IDE, RTR, ID_VALID, BUSY, FORM_ERR, ACCEPT
    );
`endif
endinterface

// File: rtl/can_arb_field_ctrl.sv
// CAN arbitration-field sequencer: assembles the 29-bit identifier and strobes it to the decoder.
// Optional macro CAN_ACCEPT_FILTER_EN enables the acceptance filter (ACCEPT is tied high otherwise).
module can_arb_field_ctrl #(
    parameter int IDLE_BITS = 11,
    parameter int CNT_W     = 5
) (
    input logic              clk,
    input logic              reset,
    can_arb_field_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE_WAIT,
        S_IDLE,
        S_BASE_ID,
        S_SRR_RTR,
        S_IDE_BIT,
        S_EXT_ID,
        S_RTR_EXT,
        S_HOLD
    } state_t;

    localparam logic [CNT_W-1:0] C_IDLE_LAST = CNT_W'(IDLE_BITS - 1);
    localparam logic [CNT_W-1:0] C_BASE_LAST = CNT_W'(10);
    localparam logic [CNT_W-1:0] C_EXT_LAST  = CNT_W'(17);

    state_t             r_state, w_state;
    logic [CNT_W-1:0]   r_cnt, w_cnt;
    logic [28:0]        r_shadow, w_shadow;
    logic               r_srr_rtr, w_srr_rtr;
    logic [28:0]        r_idtfr, w_idtfr;
    logic               r_ide, w_ide;
    logic               r_rtr, w_rtr;
    logic               r_id_valid, w_id_valid;
    logic               r_busy, w_busy;
    logic               r_form_err, w_form_err;
    logic               r_accept, w_accept;
    logic               w_bit;

    assign w_bit = bus.SP & ~bus.STUFF;

`ifdef CAN_ACCEPT_FILTER_EN
    // Standard frames compare the base ID only; extended ID mask bits are ignored.
    function automatic logic f_accept(input logic [28:0] id, input logic ext,
                                      input logic [28:0] code, input logic [28:0] mask);
        logic [28:0] m;
        m = mask;
        if (!ext) m[28:11] = '0;
        return (((id ^ code) & m) == 29'd0);
    endfunction
`endif

    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_shadow   = r_shadow;
        w_srr_rtr  = r_srr_rtr;
        w_idtfr    = r_idtfr;
        w_ide      = r_ide;
        w_rtr      = r_rtr;
        w_id_valid = 1'b0;
        w_busy     = r_busy;
        w_form_err = 1'b0;
        w_accept   = r_accept;

        // Frame end/abort outranks a bit event on the same edge, so no late commit slips through.
        if (bus.FRAME_END && (r_state != S_IDLE_WAIT)) begin
            w_state  = S_IDLE_WAIT;
            w_cnt    = '0;
            w_busy   = 1'b0;
            w_shadow = '0;
        end else if (w_bit) begin
            case (r_state)
                S_IDLE_WAIT: begin
                    if (bus.RX_BIT) begin
                        if (r_cnt == C_IDLE_LAST) begin
                            w_state = S_IDLE;
                            w_cnt   = '0;
                        end else begin
                            w_cnt = r_cnt + CNT_W'(1);
                        end
                    end else begin
                        w_cnt = '0;
                    end
                end
                S_IDLE: begin
                    if (!bus.RX_BIT) begin
                        w_state  = S_BASE_ID;
                        w_cnt    = '0;
                        w_busy   = 1'b1;
                        w_shadow = '0;
                    end
                end
                S_BASE_ID: begin
                    w_shadow[10:0] = {r_shadow[9:0], bus.RX_BIT};
                    if (r_cnt == C_BASE_LAST) begin
                        w_state = S_SRR_RTR;
                        w_cnt   = '0;
                    end else begin
                        w_cnt = r_cnt + CNT_W'(1);
                    end
                end
                S_SRR_RTR: begin
                    w_srr_rtr = bus.RX_BIT;
                    w_state   = S_IDE_BIT;
                end
                S_IDE_BIT: begin
                    if (!bus.RX_BIT) begin
                        w_idtfr    = {18'd0, r_shadow[10:0]};
                        w_ide      = 1'b0;
                        w_rtr      = r_srr_rtr;
                        w_id_valid = 1'b1;
                        w_busy     = 1'b0;
                        w_state    = S_HOLD;
`ifdef CAN_ACCEPT_FILTER_EN
                        w_accept   = f_accept({18'd0, r_shadow[10:0]}, 1'b0,
                                              bus.ACC_CODE, bus.ACC_MASK);
`endif
                    end else if (!r_srr_rtr) begin
                        w_form_err = 1'b1;
                        w_busy     = 1'b0;
                        w_state    = S_IDLE_WAIT;
                        w_cnt      = '0;
                    end else begin
                        w_state = S_EXT_ID;
                        w_cnt   = '0;
                    end
                end
                S_EXT_ID: begin
                    w_shadow[28:11] = {r_shadow[27:11], bus.RX_BIT};
                    if (r_cnt == C_EXT_LAST) begin
                        w_state = S_RTR_EXT;
                        w_cnt   = '0;
                    end else begin
                        w_cnt = r_cnt + CNT_W'(1);
                    end
                end
                S_RTR_EXT: begin
                    w_idtfr    = r_shadow;
                    w_ide      = 1'b1;
                    w_rtr      = bus.RX_BIT;
                    w_id_valid = 1'b1;
                    w_busy     = 1'b0;
                    w_state    = S_HOLD;
`ifdef CAN_ACCEPT_FILTER_EN
                    w_accept   = f_accept(r_shadow, 1'b1, bus.ACC_CODE, bus.ACC_MASK);
`endif
                end
                S_HOLD: begin
                    w_state = S_HOLD;
                end
                default: begin
                    w_state = S_IDLE_WAIT;
                    w_cnt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE_WAIT;
            r_cnt      <= '0;
            r_shadow   <= '0;
            r_srr_rtr  <= 1'b0;
            r_idtfr    <= '0;
            r_ide      <= 1'b0;
            r_rtr      <= 1'b0;
            r_id_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_form_err <= 1'b0;
            r_accept   <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_shadow   <= w_shadow;
            r_srr_rtr  <= w_srr_rtr;
            r_idtfr    <= w_idtfr;
            r_ide      <= w_ide;
            r_rtr      <= w_rtr;
            r_id_valid <= w_id_valid;
            r_busy     <= w_busy;
            r_form_err <= w_form_err;
            r_accept   <= w_accept;
        end
    end

    assign bus.IDTFR    = r_idtfr;
    assign bus.IDE      = r_ide;
    assign bus.RTR      = r_rtr;
    assign bus.ID_VALID = r_id_valid;
    assign bus.BUSY     = r_busy;
    assign bus.FORM_ERR = r_form_err;
`ifdef CAN_ACCEPT_FILTER_EN
    assign bus.ACCEPT   = r_accept;
`else
    assign bus.ACCEPT   = 1'b1;
`endif

endmodule

// File: tb/tb_can_arb_field_ctrl.sv
// Directed bench for can_arb_field_ctrl: idle detect, standard/extended capture, stuff bits,
// form error, abort and reset; acceptance results follow CAN_ACCEPT_FILTER_EN.
module tb_can_arb_field_ctrl;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    can_arb_field_ctrl_if u_if();

    can_arb_field_ctrl #(.IDLE_BITS(11), .CNT_W(5)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_vld   = 0;
    int n_ferr  = 0;

    logic [28:0] exp_ext;
    logic        exp_acc_hit;
    logic        exp_acc_miss;

    // Pulse counters see the pre-edge value of each strobe.
    always @(posedge clk) begin
        if (u_if.ID_VALID === 1'b1) n_vld++;
        if (u_if.FORM_ERR === 1'b1) n_ferr++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b, input logic st);
        @(negedge clk);
        u_if.SP     = 1'b1;
        u_if.STUFF  = st;
        u_if.RX_BIT = b;
        @(negedge clk);
        u_if.SP     = 1'b0;
        u_if.STUFF  = 1'b0;
    endtask

    task automatic send_field(input logic [17:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i], 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1, 1'b0);
    endtask

    task automatic frame_end();
        @(negedge clk);
        u_if.FRAME_END = 1'b1;
        @(negedge clk);
        u_if.FRAME_END = 1'b0;
    endtask

    initial begin
        u_if.SP        = 1'b0;
        u_if.STUFF     = 1'b0;
        u_if.RX_BIT    = 1'b1;
        u_if.FRAME_END = 1'b0;
`ifdef CAN_ACCEPT_FILTER_EN
        u_if.ACC_CODE  = 29'h123;
        u_if.ACC_MASK  = 29'h7FF;
        exp_acc_hit    = 1'b1;
        exp_acc_miss   = 1'b0;
`else
        exp_acc_hit    = 1'b1;
        exp_acc_miss   = 1'b1;
`endif
        exp_ext = {18'h2F0F1, 11'h4A5};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_idtfr",    u_if.IDTFR,    0);
        chk("rst_ide",      u_if.IDE,      0);
        chk("rst_rtr",      u_if.RTR,      0);
        chk("rst_valid",    u_if.ID_VALID, 0);
        chk("rst_busy",     u_if.BUSY,     0);
        chk("rst_form_err", u_if.FORM_ERR, 0);
`ifdef CAN_ACCEPT_FILTER_EN
        chk("rst_accept",   u_if.ACCEPT,   0);
`else
        chk("rst_accept",   u_if.ACCEPT,   1);
`endif

        // Idle detection: 10 recessive bits are not enough, 11 are.
        idle(10);
        send_bit(1'b0, 1'b0);
        chk("idle10_busy", u_if.BUSY, 0);
        idle(11);
        send_bit(1'b0, 1'b0);
        chk("idle11_sof_busy", u_if.BUSY, 1);

        // Abort after 5 base-ID bits.
        send_field(18'h16, 5);
        frame_end();
        chk("abort_busy", u_if.BUSY, 0);
        send_bit(1'b0, 1'b0);
        chk("abort_idle_wait", u_if.BUSY, 0);

        // A stuff bit during idle counting neither counts nor clears.
        idle(5);
        send_bit(1'b0, 1'b1);
        idle(6);
        send_bit(1'b0, 1'b0);
        chk("stuff_idle_cnt", u_if.BUSY, 1);
        frame_end();
        chk("abort_no_valid", n_vld, 0);

        // Standard frame ID 0x123, RTR=0.
        idle(11);
        send_bit(1'b0, 1'b0);
        send_field(18'h123, 11);
        send_bit(1'b0, 1'b0);
        chk("std_pre_valid", u_if.ID_VALID, 0);
        chk("std_pre_busy",  u_if.BUSY,     1);
        send_bit(1'b0, 1'b0);
        chk("std_valid",  u_if.ID_VALID, 1);
        chk("std_idtfr",  u_if.IDTFR,    29'h0000123);
        chk("std_ide",    u_if.IDE,      0);
        chk("std_rtr",    u_if.RTR,      0);
        chk("std_busy",   u_if.BUSY,     0);
        chk("std_accept", u_if.ACCEPT,   exp_acc_hit);
        @(negedge clk);
        chk("std_valid_width", u_if.ID_VALID, 0);
        chk("std_valid_count", n_vld, 1);
        frame_end();

        // Standard frame ID 0x124, RTR=1: filter miss, still strobed.
        idle(11);
        send_bit(1'b0, 1'b0);
        send_field(18'h124, 11);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        chk("std2_valid",  u_if.ID_VALID, 1);
        chk("std2_idtfr",  u_if.IDTFR,    29'h0000124);
        chk("std2_rtr",    u_if.RTR,      1);
        chk("std2_accept", u_if.ACCEPT,   exp_acc_miss);
        frame_end();
        chk("std2_valid_count", n_vld, 2);

        // Extended frame with a stuff bit in the base ID and one in the extended ID.
        idle(11);
        send_bit(1'b0, 1'b0);
        send_field(18'h9, 4);
        send_bit(1'b0, 1'b1);
        send_field(18'h25, 7);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_field(18'h2F, 6);
        send_bit(1'b0, 1'b1);
        send_field(18'h0F1, 12);
        chk("ext_pre_valid", u_if.ID_VALID, 0);
        send_bit(1'b1, 1'b0);
        chk("ext_valid",  u_if.ID_VALID, 1);
        chk("ext_idtfr",  u_if.IDTFR,    exp_ext);
        chk("ext_ide",    u_if.IDE,      1);
        chk("ext_rtr",    u_if.RTR,      1);
        chk("ext_busy",   u_if.BUSY,     0);
        chk("ext_accept", u_if.ACCEPT,   exp_acc_miss);
        frame_end();

        // Extended frame with dominant SRR: form error, no commit.
        idle(11);
        send_bit(1'b0, 1'b0);
        send_field(18'h0AA, 11);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("ferr_pulse", u_if.FORM_ERR, 1);
        chk("ferr_valid", u_if.ID_VALID, 0);
        chk("ferr_busy",  u_if.BUSY,     0);
        chk("ferr_idtfr", u_if.IDTFR,    exp_ext);
        @(negedge clk);
        chk("ferr_width", u_if.FORM_ERR, 0);
        chk("ferr_count", n_ferr, 1);
        chk("ferr_valid_count", n_vld, 3);

        // FRAME_END coinciding with the completing IDE bit suppresses the commit.
        idle(11);
        send_bit(1'b0, 1'b0);
        send_field(18'h155, 11);
        send_bit(1'b0, 1'b0);
        @(negedge clk);
        u_if.SP        = 1'b1;
        u_if.RX_BIT    = 1'b0;
        u_if.FRAME_END = 1'b1;
        @(negedge clk);
        u_if.SP        = 1'b0;
        u_if.FRAME_END = 1'b0;
        chk("race_valid", u_if.ID_VALID, 0);
        chk("race_busy",  u_if.BUSY,     0);
        chk("race_idtfr", u_if.IDTFR,    exp_ext);
        @(negedge clk);
        chk("race_valid_count", n_vld, 3);

        // Reset in the middle of the extended ID, with a bit event on the same edge.
        idle(11);
        send_bit(1'b0, 1'b0);
        send_field(18'h3C3, 11);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_field(18'h1B, 5);
        chk("mid_ext_busy", u_if.BUSY, 1);
        @(negedge clk);
        reset       = 1'b1;
        u_if.SP     = 1'b1;
        u_if.RX_BIT = 1'b1;
        @(negedge clk);
        reset       = 1'b0;
        u_if.SP     = 1'b0;
        chk("mid_rst_idtfr", u_if.IDTFR,    0);
        chk("mid_rst_ide",   u_if.IDE,      0);
        chk("mid_rst_rtr",   u_if.RTR,      0);
        chk("mid_rst_valid", u_if.ID_VALID, 0);
        chk("mid_rst_busy",  u_if.BUSY,     0);
        chk("mid_rst_ferr",  u_if.FORM_ERR, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
